// File: rtl/soc_rst_seq_if.sv
// Board/VIO reset inputs and sequenced reset/status outputs of soc_rst_seq.
// The sequencer owns the slave side; the board/VIO glue owns the master side.
interface soc_rst_seq_if;
  logic       btn_rst_ni;
  logic       vio_rst_i;
  logic       mmcm_locked_i;
  logic       calib_done_i;
  logic       dram_axi_rst_no;
  logic       soc_rst_no;
  logic       calib_timeout_o;
  logic [2:0] state_o;
  logic [7:0] rst_count_o;

  modport master (
    output btn_rst_ni,
    output vio_rst_i,
    output mmcm_locked_i,
    output calib_done_i,
    input  dram_axi_rst_no,
    input  soc_rst_no,
    input  calib_timeout_o,
    input  state_o,
    input  rst_count_o
  );

  modport slave (
    input  btn_rst_ni,
    input  vio_rst_i,
    input  mmcm_locked_i,
    input  calib_done_i,
    output dram_axi_rst_no,
    output soc_rst_no,
    output calib_timeout_o,
    output state_o,
    output rst_count_o
  );
endinterface

// File: rtl/soc_rst_seq.sv
// FPGA reset sequencer: releases the DRAM AXI reset, waits for MIG
// calibration, then releases the SoC reset after a fixed gap.
module soc_rst_seq #(
  parameter int SyncStages      = 2,
  parameter int DebounceCycles  = 50000,
  parameter int HoldCycles      = 16,
  parameter int DramToSocCycles = 64,
  parameter int CalibTimeout    = 10000000
) (
  input logic          clk_i,
  input logic          rst_i,
  soc_rst_seq_if.slave io
);

  localparam int DebW =
    (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam int HoldW =
    (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
  localparam int GapW =
    (DramToSocCycles > 1) ? $clog2(DramToSocCycles) : 1;
  localparam int CalW =
    (CalibTimeout > 1) ? $clog2(CalibTimeout) : 1;

  localparam logic [DebW-1:0] DebMax =
    DebW'(DebounceCycles - 1);
  localparam logic [HoldW-1:0] HoldMax =
    HoldW'(HoldCycles - 1);
  localparam logic [GapW-1:0] GapMax =
    GapW'(DramToSocCycles - 1);
  localparam logic [CalW-1:0] CalMax =
    CalW'(CalibTimeout - 1);

  typedef enum logic [2:0] {
    ST_ASSERT     = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_REL_DRAM   = 3'd2,
    ST_WAIT_CALIB = 3'd3,
    ST_GAP        = 3'd4,
    ST_RUN        = 3'd5,
    ST_ERROR      = 3'd6
  } state_e;

  logic [SyncStages-1:0] btn_sync_q, btn_sync_d;
  logic [SyncStages-1:0] lock_sync_q, lock_sync_d;
  logic [SyncStages-1:0] cal_sync_q, cal_sync_d;

  logic            btn_deb_q, btn_deb_d;
  logic [DebW-1:0] deb_cnt_q, deb_cnt_d;

  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [CalW-1:0]  cal_q, cal_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             tmo_q, tmo_d;
  logic [7:0]       count_q, count_d;
  logic             dram_q, dram_d;
  logic             soc_q, soc_d;

  logic btn_sync;
  logic locked_sync;
  logic calib_sync;
  logic req;

  assign btn_sync    = btn_sync_q[SyncStages-1];
  assign locked_sync = lock_sync_q[SyncStages-1];
  assign calib_sync  = cal_sync_q[SyncStages-1];

  always_comb begin
    btn_sync_d  = {btn_sync_q[SyncStages-2:0], io.btn_rst_ni};
    lock_sync_d = {lock_sync_q[SyncStages-2:0], io.mmcm_locked_i};
    cal_sync_d  = {cal_sync_q[SyncStages-2:0], io.calib_done_i};
  end

  // Counter only runs while the synced level disagrees with the debounced one
  always_comb begin
    btn_deb_d = btn_deb_q;
    deb_cnt_d = '0;
    if (btn_sync != btn_deb_q) begin
      if (deb_cnt_q == DebMax) begin
        btn_deb_d = btn_sync;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  assign req = ~btn_deb_q | io.vio_rst_i | ~locked_sync;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cal_d   = cal_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    count_d = count_q;
    if (req && (state_q != ST_ASSERT)) begin
      state_d = ST_ASSERT;
      hold_d  = '0;
      cal_d   = '0;
      gap_d   = '0;
      tmo_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          if (hold_q != HoldMax) begin
            hold_d = hold_q + 1'b1;
          end else if (!req) begin
            state_d = ST_WAIT_LOCK;
            hold_d  = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_sync) state_d = ST_REL_DRAM;
        end
        ST_REL_DRAM: begin
          state_d = ST_WAIT_CALIB;
          cal_d   = '0;
        end
        ST_WAIT_CALIB: begin
          if (calib_sync) begin
            state_d = ST_GAP;
            cal_d   = '0;
            gap_d   = '0;
          end else if (cal_q == CalMax) begin
            state_d = ST_ERROR;
            cal_d   = '0;
            tmo_d   = 1'b1;
          end else begin
            cal_d = cal_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_q == GapMax) begin
            state_d = ST_RUN;
            gap_d   = '0;
            if (count_q != 8'hff) count_d = count_q + 8'd1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        ST_RUN:   state_d = ST_RUN;
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_ASSERT;
      endcase
    end
    // Outputs decode the next state so they leave the flops glitch-free
    dram_d = (state_d != ST_ASSERT) && (state_d != ST_WAIT_LOCK);
    soc_d  = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btn_sync_q  <= '1;
      lock_sync_q <= '0;
      cal_sync_q  <= '0;
      btn_deb_q   <= 1'b1;
      deb_cnt_q   <= '0;
      state_q     <= ST_ASSERT;
      hold_q      <= '0;
      cal_q       <= '0;
      gap_q       <= '0;
      tmo_q       <= 1'b0;
      count_q     <= '0;
      dram_q      <= 1'b0;
      soc_q       <= 1'b0;
    end else begin
      btn_sync_q  <= btn_sync_d;
      lock_sync_q <= lock_sync_d;
      cal_sync_q  <= cal_sync_d;
      btn_deb_q   <= btn_deb_d;
      deb_cnt_q   <= deb_cnt_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      cal_q       <= cal_d;
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
      count_q     <= count_d;
      dram_q      <= dram_d;
      soc_q       <= soc_d;
    end
  end

  assign io.dram_axi_rst_no = dram_q;
  assign io.soc_rst_no      = soc_q;
  assign io.calib_timeout_o = tmo_q;
  assign io.state_o         = state_q;
  assign io.rst_count_o     = count_q;

endmodule

// File: tb/tb_soc_rst_seq.sv
// Bench for soc_rst_seq: directed scenarios plus random input noise,
// checked every cycle against a phase/elapsed-time reference model.
module tb_soc_rst_seq;
  localparam int SYNC = 2;
  localparam int DEB  = 64;
  localparam int HOLD = 16;
  localparam int GAPC = 64;
  localparam int CTO  = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  soc_rst_seq_if bus ();

  soc_rst_seq #(
    .SyncStages(SYNC),
    .DebounceCycles(DEB),
    .HoldCycles(HOLD),
    .DramToSocCycles(GAPC),
    .CalibTimeout(CTO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .io(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  logic [SYNC-1:0] m_btn, m_lk, m_cal;
  logic m_deb, m_tmo;
  int m_stab, m_ph, m_entry, m_cnt;
  int cyc = 0;

  task automatic model_step();
    logic req;
    int el;
    cyc++;
    req = !m_deb || bus.vio_rst_i || !m_lk[SYNC-1];
    el = cyc - m_entry;
    if (rst) begin
      m_ph = 0; m_entry = cyc; m_tmo = 0; m_cnt = 0;
    end else if (m_ph != 0 && req) begin
      m_ph = 0; m_entry = cyc; m_tmo = 0;
    end else begin
      case (m_ph)
        0: if (el >= HOLD && !req) begin
             m_ph = 1; m_entry = cyc;
           end
        1: if (m_lk[SYNC-1]) begin
             m_ph = 2; m_entry = cyc;
           end
        2: begin m_ph = 3; m_entry = cyc; end
        3: if (m_cal[SYNC-1]) begin
             m_ph = 4; m_entry = cyc;
           end else if (el == CTO) begin
             m_ph = 6; m_entry = cyc; m_tmo = 1;
           end
        4: if (el == GAPC) begin
             m_ph = 5; m_entry = cyc;
             if (m_cnt < 255) m_cnt++;
           end
        default: ;
      endcase
    end
    if (rst) begin
      m_btn = '1; m_lk = '0; m_cal = '0;
      m_deb = 1'b1; m_stab = 0;
    end else begin
      if (m_btn[SYNC-1] !== m_deb) begin
        m_stab++;
        if (m_stab == DEB) begin
          m_deb = m_btn[SYNC-1];
          m_stab = 0;
        end
      end else begin
        m_stab = 0;
      end
      m_btn = {m_btn[SYNC-2:0], bus.btn_rst_ni};
      m_lk  = {m_lk[SYNC-2:0], bus.mmcm_locked_i};
      m_cal = {m_cal[SYNC-2:0], bus.calib_done_i};
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("state", bus.state_o, m_ph);
    chk("dram", bus.dram_axi_rst_no, (m_ph >= 2) ? 1 : 0);
    chk("soc", bus.soc_rst_no, (m_ph == 5) ? 1 : 0);
    chk("tmo", bus.calib_timeout_o, m_tmo);
    chk("count", bus.rst_count_o, m_cnt);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_state(input int s, input int budget,
                            input string tag);
    int i;
    i = 0;
    while (bus.state_o !== 3'(s) && i < budget) begin
      cycle();
      i++;
    end
    chk(tag, bus.state_o, s);
  endtask

  task automatic vio_pulse();
    bus.vio_rst_i = 1'b1;
    cycle();
    bus.vio_rst_i = 1'b0;
  endtask

  int e_rst, e_cal, n;

  initial begin
    rst = 1'b1;
    bus.btn_rst_ni    = 1'b1;
    bus.vio_rst_i     = 1'b0;
    bus.mmcm_locked_i = 1'b1;
    bus.calib_done_i  = 1'b0;
    run(5);
    chk("rst_state", bus.state_o, 0);
    chk("rst_dram", bus.dram_axi_rst_no, 0);
    chk("rst_soc", bus.soc_rst_no, 0);
    e_rst = cyc;
    rst = 1'b0;

    n = 0;
    while (bus.dram_axi_rst_no !== 1'b1 && n < 100) begin
      cycle();
      n++;
    end
    chk("dram_rise", cyc - e_rst, HOLD + 1);
    run(100 - (cyc - e_rst));
    bus.calib_done_i = 1'b1;
    e_cal = cyc + 1;
    n = 0;
    while (bus.soc_rst_no !== 1'b1 && n < 200) begin
      cycle();
      n++;
    end
    chk("soc_gap", cyc - e_cal, SYNC + GAPC);
    chk("cnt1", bus.rst_count_o, 1);
    chk("run1", bus.state_o, 5);

    for (int t = 0; t < 10; t++) begin
      bus.btn_rst_ni = ~bus.btn_rst_ni;
      run($urandom_range(2, DEB / 2));
    end
    run(DEB + 10);
    chk("bounce_run", bus.state_o, 5);
    bus.btn_rst_ni = 1'b0;
    run(DEB + SYNC + 5);
    chk("press_state", bus.state_o, 0);
    chk("press_dram", bus.dram_axi_rst_no, 0);
    chk("press_soc", bus.soc_rst_no, 0);
    bus.btn_rst_ni = 1'b1;
    wait_state(5, 500, "press_rerun");
    chk("cnt2", bus.rst_count_o, 2);

    vio_pulse();
    chk("vio_dram", bus.dram_axi_rst_no, 0);
    chk("vio_soc", bus.soc_rst_no, 0);
    n = 1;
    while (bus.dram_axi_rst_no !== 1'b1 && n < 100) begin
      cycle();
      if (bus.dram_axi_rst_no !== 1'b1) n++;
    end
    chk("vio_low", n, HOLD + 1);
    wait_state(5, 300, "vio_rerun");
    chk("cnt3", bus.rst_count_o, 3);

    bus.calib_done_i = 1'b0;
    vio_pulse();
    wait_state(3, 100, "to_wait_calib");
    n = 0;
    while (bus.state_o === 3'd3 && n < CTO + 50) begin
      cycle();
      n++;
    end
    chk("tmo_len", n, CTO);
    chk("tmo_state", bus.state_o, 6);
    chk("tmo_flag", bus.calib_timeout_o, 1);
    chk("tmo_dram", bus.dram_axi_rst_no, 1);
    chk("tmo_soc", bus.soc_rst_no, 0);
    vio_pulse();
    chk("tmo_clear", bus.calib_timeout_o, 0);
    bus.calib_done_i = 1'b1;
    wait_state(5, 300, "tmo_rerun");
    chk("cnt4", bus.rst_count_o, 4);

    bus.mmcm_locked_i = 1'b0;
    n = 0;
    while (bus.state_o !== 3'd0 && n < 20) begin
      cycle();
      n++;
    end
    chk("lock_lat", n, SYNC + 1);
    run(30);
    chk("lock_hold", bus.state_o, 0);
    bus.mmcm_locked_i = 1'b1;
    wait_state(5, 300, "lock_rerun");
    chk("cnt5", bus.rst_count_o, 5);

    for (int i = 0; i < 3000; i++) begin
      bus.vio_rst_i = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 299) == 0)
        bus.mmcm_locked_i = ~bus.mmcm_locked_i;
      if ($urandom_range(0, 149) == 0)
        bus.calib_done_i = ~bus.calib_done_i;
      if ($urandom_range(0, 49) == 0)
        bus.btn_rst_ni = ~bus.btn_rst_ni;
      rst = ($urandom_range(0, 999) == 0);
      cycle();
    end
    rst = 1'b0;
    bus.vio_rst_i = 1'b0;
    bus.mmcm_locked_i = 1'b1;
    bus.calib_done_i = 1'b1;
    bus.btn_rst_ni = 1'b1;
    wait_state(5, 2000, "rand_settle");

    for (int i = 0; i < 260; i++) begin
      vio_pulse();
      wait_state(5, 300, "sat_seq");
    end
    chk("sat", bus.rst_count_o, 255);

    vio_pulse();
    wait_state(4, 100, "to_gap");
    run(10);
    rst = 1'b1;
    cycle();
    chk("midrst_state", bus.state_o, 0);
    chk("midrst_dram", bus.dram_axi_rst_no, 0);
    chk("midrst_soc", bus.soc_rst_no, 0);
    chk("midrst_cnt", bus.rst_count_o, 0);
    rst = 1'b0;
    run(5);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
